// File: rtl/xbar_bank_arb_if.sv
// rtl/xbar_bank_arb_if.sv - channel request and bank HTU bus bundle for xbar_bank_arb
interface xbar_bank_arb_if;
    logic [3:0]   ch_valid_i;
    logic [3:0]   ch_ready_o;
    logic [7:0]   ch_opcode_i;
    logic [111:0] ch_addr_i;
    logic [31:0]  ch_wbuffer_id_i;
    logic         xbar_bank_htu_valid_o;
    logic         xbar_bank_htu_ready_i;
    logic [1:0]   xbar_bank_htu_ch_id_o;
    logic [1:0]   xbar_bank_htu_opcode_o;
    logic [27:0]  xbar_bank_htu_addr_o;
    logic [7:0]   xbar_bank_htu_wbuffer_id_o;
    logic [15:0]  gnt_cnt_o;

    // Arbiter side.
    modport slave (
        input  ch_valid_i, ch_opcode_i, ch_addr_i, ch_wbuffer_id_i, xbar_bank_htu_ready_i,
        output ch_ready_o, xbar_bank_htu_valid_o, xbar_bank_htu_ch_id_o,
               xbar_bank_htu_opcode_o, xbar_bank_htu_addr_o, xbar_bank_htu_wbuffer_id_o,
               gnt_cnt_o
    );

    // Requester / HTU side.
    modport master (
        output ch_valid_i, ch_opcode_i, ch_addr_i, ch_wbuffer_id_i, xbar_bank_htu_ready_i,
        input  ch_ready_o, xbar_bank_htu_valid_o, xbar_bank_htu_ch_id_o,
               xbar_bank_htu_opcode_o, xbar_bank_htu_addr_o, xbar_bank_htu_wbuffer_id_o,
               gnt_cnt_o
    );
endinterface

// File: rtl/xbar_bank_arb.sv
// rtl/xbar_bank_arb.sv - 4-channel round-robin arbiter feeding one bank HTU through a single register slot
module xbar_bank_arb #(
    parameter logic [1:0] BANK_ID = 2'd0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    xbar_bank_arb_if.slave bus
);
    logic [3:0]  w_elig;
    logic        w_any;
    logic [1:0]  w_winner;
    logic [1:0]  w_idx;
    logic        w_slot_free;
    logic        w_load;
    logic [3:0]  w_ready;

    logic        r_valid;
    logic [1:0]  r_ch_id;
    logic [1:0]  r_opcode;
    logic [27:0] r_addr;
    logic [7:0]  r_wbuf;
    logic [1:0]  r_rr_ptr;
    logic [15:0] r_gnt_cnt;

    // addr[5:4] sits in the two LSBs of each packed addr[31:4] field.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_elig[i] = bus.ch_valid_i[i] && (bus.ch_addr_i[i*28 +: 2] == BANK_ID);
        end
    end

    always_comb begin
        w_winner = r_rr_ptr;
        w_any    = 1'b0;
        w_idx    = r_rr_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_rr_ptr + 2'(k);
            if (!w_any && w_elig[w_idx]) begin
                w_winner = w_idx;
                w_any    = 1'b1;
            end
        end
    end

    // rst_i gates load so no channel is readied while reset is held.
    assign w_slot_free = !r_valid || bus.xbar_bank_htu_ready_i;
    assign w_load      = w_any && w_slot_free && rst_i;

    always_comb begin
        w_ready = 4'b0000;
        if (w_load) begin
            w_ready[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid   <= 1'b0;
            r_ch_id   <= 2'd0;
            r_opcode  <= 2'd0;
            r_addr    <= 28'd0;
            r_wbuf    <= 8'd0;
            r_rr_ptr  <= 2'd0;
            r_gnt_cnt <= 16'd0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_ch_id   <= w_winner;
            r_opcode  <= bus.ch_opcode_i[w_winner*2 +: 2];
            r_addr    <= bus.ch_addr_i[w_winner*28 +: 28];
            r_wbuf    <= bus.ch_wbuffer_id_i[w_winner*8 +: 8];
            r_rr_ptr  <= w_winner + 2'd1;
            r_gnt_cnt <= r_gnt_cnt + 16'd1;
        end else if (bus.xbar_bank_htu_ready_i) begin
            r_valid   <= 1'b0;
        end
    end

    assign bus.ch_ready_o                 = w_ready;
    assign bus.xbar_bank_htu_valid_o      = r_valid;
    assign bus.xbar_bank_htu_ch_id_o      = r_ch_id;
    assign bus.xbar_bank_htu_opcode_o     = r_opcode;
    assign bus.xbar_bank_htu_addr_o       = r_addr;
    assign bus.xbar_bank_htu_wbuffer_id_o = r_wbuf;
    assign bus.gnt_cnt_o                  = r_gnt_cnt;
endmodule

// File: tb/tb_xbar_bank_arb.sv
// tb/tb_xbar_bank_arb.sv - directed table-driven bench for xbar_bank_arb
module tb_xbar_bank_arb;
    logic clk_i;
    logic rst_i;
    int   n_checks;
    int   n_fail;

    xbar_bank_arb_if bus();

    xbar_bank_arb #(.BANK_ID(2'd0)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  match;
        logic        rdy;
        logic [3:0]  exp_ready;
        logic        exp_valid;
        logic [1:0]  exp_id;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0]  exp_opc(input logic [1:0] id);  return ~id; endfunction
    function automatic logic [7:0]  exp_wbuf(input logic [1:0] id); return 8'h58 + 8'(id); endfunction
    function automatic logic [27:0] exp_addr(input logic [1:0] id); return {26'h1234 + 26'(id), 2'b00}; endfunction

    // Matching channels target bank 0; others target bank 2.
    task automatic drive(input logic [3:0] valid, input logic [3:0] match, input logic rdy);
        for (int i = 0; i < 4; i++) begin
            bus.ch_opcode_i[i*2 +: 2]     = exp_opc(2'(i));
            bus.ch_wbuffer_id_i[i*8 +: 8] = exp_wbuf(2'(i));
            bus.ch_addr_i[i*28 +: 28]     = {26'h1234 + 26'(i), (match[i] ? 2'd0 : 2'd2)};
        end
        bus.ch_valid_i            = valid;
        bus.xbar_bank_htu_ready_i = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(4'b0000, 4'b1111, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic check_presented(input string name, input logic [1:0] id);
        check({name, "_valid"}, 32'(bus.xbar_bank_htu_valid_o), 32'd1);
        check({name, "_id"},    32'(bus.xbar_bank_htu_ch_id_o), 32'(id));
        check({name, "_opc"},   32'(bus.xbar_bank_htu_opcode_o), 32'(exp_opc(id)));
        check({name, "_addr"},  32'(bus.xbar_bank_htu_addr_o), 32'(exp_addr(id)));
        check({name, "_wbuf"},  32'(bus.xbar_bank_htu_wbuffer_id_o), 32'(exp_wbuf(id)));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_i    = 1'b0;
        drive(4'b0000, 4'b1111, 1'b0);

        // Sequential vectors from reset; state carries from one row to the next.
        vecs[0] = '{4'b0100, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'd1};
        vecs[1] = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'd2};
        vecs[2] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'd3};
        vecs[3] = '{4'b0010, 4'b1101, 1'b1, 4'b0000, 1'b0, 2'd0, 16'd3};
        vecs[4] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 16'd3};
        vecs[5] = '{4'b1001, 4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 16'd4};
        vecs[6] = '{4'b1001, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 16'd4};
        vecs[7] = '{4'b1001, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'd5};

        drive(4'b1111, 4'b1111, 1'b1);
        #2;
        check("rst_ready",  32'(bus.ch_ready_o), 32'd0);
        check("rst_valid",  32'(bus.xbar_bank_htu_valid_o), 32'd0);
        check("rst_id",     32'(bus.xbar_bank_htu_ch_id_o), 32'd0);
        check("rst_addr",   32'(bus.xbar_bank_htu_addr_o), 32'd0);
        check("rst_wbuf",   32'(bus.xbar_bank_htu_wbuffer_id_o), 32'd0);
        check("rst_cnt",    32'(bus.gnt_cnt_o), 32'd0);
        do_reset();

        for (int v = 0; v < 8; v++) begin
            drive(vecs[v].valid, vecs[v].match, vecs[v].rdy);
            #1;
            check($sformatf("vec%0d_ready", v), 32'(bus.ch_ready_o), 32'(vecs[v].exp_ready));
            @(posedge clk_i);
            #1;
            check($sformatf("vec%0d_valid", v), 32'(bus.xbar_bank_htu_valid_o), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_id", v),    32'(bus.xbar_bank_htu_ch_id_o), 32'(vecs[v].exp_id));
            check($sformatf("vec%0d_cnt", v),   32'(bus.gnt_cnt_o), 32'(vecs[v].exp_cnt));
            if (vecs[v].exp_valid)
                check($sformatf("vec%0d_wbuf", v), 32'(bus.xbar_bank_htu_wbuffer_id_o),
                      32'(exp_wbuf(vecs[v].exp_id)));
            @(negedge clk_i);
        end

        // Single ch2 grant: pointer lands on 3.
        do_reset();
        drive(4'b0100, 4'b1111, 1'b1);
        #1;
        check("single_ready", 32'(bus.ch_ready_o), 32'b0100);
        @(posedge clk_i); #1;
        check_presented("single", 2'd2);
        check("single_rr", 32'(dut.r_rr_ptr), 32'd3);

        // Sustained all-eligible: order 0,1,2,3,0.
        do_reset();
        drive(4'b1111, 4'b1111, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1;
            check($sformatf("rr_order%0d", c), 32'(bus.xbar_bank_htu_ch_id_o), 32'(c % 4));
        end
        check("rr_cnt5", 32'(bus.gnt_cnt_o), 32'd5);

        // Stall with ch1 presented, then release to ch3.
        do_reset();
        drive(4'b0010, 4'b1111, 1'b1);
        @(posedge clk_i);
        @(negedge clk_i);
        drive(4'b1001, 4'b1111, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d_ready", c), 32'(bus.ch_ready_o), 32'd0);
            @(posedge clk_i); #1;
            check_presented($sformatf("stall%0d", c), 2'd1);
            @(negedge clk_i);
        end
        drive(4'b1001, 4'b1111, 1'b1);
        #1;
        check("unstall_ready", 32'(bus.ch_ready_o), 32'b1000);
        @(posedge clk_i); #1;
        check_presented("unstall", 2'd3);

        // Wrong-bank request is never readied.
        do_reset();
        drive(4'b0010, 4'b1101, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bank_ready%0d", c), 32'(bus.ch_ready_o), 32'd0);
            @(posedge clk_i); #1;
            check($sformatf("bank_valid%0d", c), 32'(bus.xbar_bank_htu_valid_o), 32'd0);
            check($sformatf("bank_cnt%0d", c),   32'(bus.gnt_cnt_o), 32'd0);
            @(negedge clk_i);
        end

        // Async reset mid-cycle discards the slot; first edge after release loads.
        do_reset();
        drive(4'b0010, 4'b1111, 1'b0);
        @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        #1;
        check("areset_valid", 32'(bus.xbar_bank_htu_valid_o), 32'd0);
        check("areset_rr",    32'(dut.r_rr_ptr), 32'd0);
        check("areset_ready", 32'(bus.ch_ready_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        drive(4'b1001, 4'b1111, 1'b0);
        #1;
        check("post_rst_ready", 32'(bus.ch_ready_o), 32'b0001);
        @(posedge clk_i); #1;
        check_presented("post_rst", 2'd0);

        // Counter wrap after 65536 grants.
        do_reset();
        drive(4'b1111, 4'b1111, 1'b1);
        repeat (65535) @(posedge clk_i);
        #1;
        check("cnt_ffff", 32'(bus.gnt_cnt_o), 32'hFFFF);
        @(posedge clk_i); #1;
        check("cnt_wrap", 32'(bus.gnt_cnt_o), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/xbar_bank_arb.md
XBAR_BANK_ARB -- requirements
Module: xbar_bank_arb

Interface
REQ-001 Parameter BANK_ID, default 2'd0: bank index this arbiter serves; compared against request addr[5:4].
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 ch_valid_i  input  4  per-channel request valid; bit i belongs to channel i.
REQ-005 ch_ready_o  output  4  per-channel accept; at most one bit high per cycle.
REQ-006 ch_opcode_i  input  4x2  per-channel opcode, packed {ch3,ch2,ch1,ch0}.
REQ-007 ch_addr_i  input  4x28  per-channel addr[31:4], packed {ch3..ch0}.
REQ-008 ch_wbuffer_id_i  input  4x8  per-channel write-buffer id, packed {ch3..ch0}.
REQ-009 xbar_bank_htu_valid_o  output  1  registered request valid toward the bank HTU.
REQ-010 xbar_bank_htu_ready_i  input  1  bank HTU accepts the presented request.
REQ-011 xbar_bank_htu_ch_id_o  output  2  index of the channel that won the presented request.
REQ-012 xbar_bank_htu_opcode_o  output  2  opcode of the presented request.
REQ-013 xbar_bank_htu_addr_o  output  28  addr[31:4] of the presented request.
REQ-014 xbar_bank_htu_wbuffer_id_o  output  8  wbuffer id of the presented request.
REQ-015 gnt_cnt_o  output  16  count of requests accepted from channels since reset.

Function
REQ-016 Channel i SHALL be eligible when ch_valid_i[i]=1 and ch_addr_i[i][5:4]==BANK_ID; non-matching requests SHALL be ignored and never readied.
REQ-017 Output stage SHALL be a single register slot; slot is free when xbar_bank_htu_valid_o=0 or xbar_bank_htu_ready_i=1.
REQ-018 load SHALL equal (any channel eligible) AND (slot free); evaluated combinationally each cycle.
REQ-019 Winner SHALL be the first eligible channel scanning rr_ptr, rr_ptr+1, ... mod 4 (2-bit round-robin pointer).
REQ-020 ch_ready_o[winner] SHALL equal load; all other ch_ready_o bits SHALL be 0.
REQ-021 On load, next edge SHALL capture winner payload into output registers, set ch_id to winner, set valid to 1, set rr_ptr to winner+1 mod 4 (3 wraps to 0).
REQ-022 Without load, rr_ptr SHALL hold; pointer advances only on an accepted grant.
REQ-023 When xbar_bank_htu_ready_i=1 and no load, valid SHALL clear next edge.
REQ-024 While valid=1 and xbar_bank_htu_ready_i=0, all xbar_bank_htu_*_o SHALL be held stable and ch_ready_o SHALL be 4'b0000.
REQ-025 Simultaneous downstream accept and load SHALL replace the slot content in the same edge (back-to-back, one request per cycle sustained).
REQ-026 Latency SHALL be exactly 1 cycle from channel handshake to xbar_bank_htu_valid_o=1.
REQ-027 gnt_cnt_o SHALL increment by 1 on each load edge, wrapping 16'hFFFF -> 16'h0000.
REQ-028 Requesters SHALL NOT drive ch_valid_i from ch_ready_o; block introduces no combinational path from xbar_bank_htu_ready_i to any output other than ch_ready_o.

Reset
REQ-029 On rst_i=0, asynchronously: xbar_bank_htu_valid_o=0, ch_id/opcode/addr/wbuffer_id outputs=0, rr_ptr=0, gnt_cnt_o=0.
REQ-030 ch_ready_o SHALL be 4'b0000 while rst_i=0.
REQ-031 Reset asserted while valid=1 SHALL discard the buffered request; no replay after release.
REQ-032 First edge after release SHALL be able to load (no dead cycle).

Verification
REQ-033 BANK_ID=0; ch2 valid, addr[5:4]=0, opcode=2'b01, wbuf=8'h5A, htu_ready=1 -> ch_ready_o=4'b0100 same cycle; next cycle valid_o=1, ch_id=2, wbuf=8'h5A; rr_ptr=3.
REQ-034 All four channels eligible continuously, htu_ready=1 -> grant order 0,1,2,3,0 on consecutive cycles; gnt_cnt_o=5 after 5 cycles.
REQ-035 Presented request ch1, htu_ready=0 for 3 cycles with ch0,ch3 valid -> outputs frozen, ch_ready_o=0; htu_ready=1 -> same cycle ch3 readied (rr_ptr=2), next cycle ch_id=3.
REQ-036 ch1 valid with addr[5:4]=2, BANK_ID=0 -> ch_ready_o[1] never asserts, valid_o stays 0, gnt_cnt_o unchanged.
REQ-037 gnt_cnt_o forced to 16'hFFFF region via 65535 grants, one more grant -> 16'h0000.
REQ-038 rst_i low mid-cycle while valid_o=1, htu_ready=0 -> valid_o=0 immediately (no edge), rr_ptr=0; after release ch3 and ch0 eligible -> ch0 wins.
